fir_result_capture: RTL and testbench

//  Output-side consumer for FIR_filter. Discards the filter warm-up samples, rounds and

---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_round_sat.sv | 38 +++
 rtl/fir_result_capture.sv | 159 +++++++++++++++
 tb/tb_fir_result_capture.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg
//  Shared constants and types for the FIR result capture block.
//  IN_W / OUT_W : width of the raw FIR result and of the stored quantised sample
//  state_t      : capture controller states
//  OUT_MAX/MIN  : 16-bit saturation limits, also widened to the rounding width
package fir_pkg;

  localparam int IN_W  = 32;
  localparam int OUT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic signed [OUT_W-1:0] OUT_MAX = 16'sh7FFF;
  localparam logic signed [OUT_W-1:0] OUT_MIN = 16'sh8000;

  // Saturation limits expressed at the 33-bit rounding width
  localparam logic signed [IN_W:0] SAT_HI = 33'sd32767;
  localparam logic signed [IN_W:0] SAT_LO = -33'sd32768;

endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat
//  Combinational quantiser: round-half-up, arithmetic right shift, clamp to 16 bits.
//  Ports:
//   din   in  IN_W   signed FIR result
//   shift in  5      right shift amount (0 = no rounding, no shift)
//   dout  out OUT_W  signed saturated result
module fir_round_sat
  import fir_pkg::*;
(
  input  logic signed [IN_W-1:0]  din,
  input  logic        [4:0]       shift,
  output logic signed [OUT_W-1:0] dout
);

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] bias;
  logic signed [IN_W:0] rounded;
  logic signed [IN_W:0] shifted;

  // One extra bit of headroom keeps the rounding add from wrapping at the positive limit
  always_comb begin
    ext  = {din[IN_W-1], din};
    bias = '0;
    if (shift != 5'd0) begin
      bias = (IN_W+1)'(1) << (shift - 5'd1);
    end
    rounded = ext + bias;
    shifted = rounded >>> shift;
    if (shifted > SAT_HI) begin
      dout = OUT_MAX;
    end else if (shifted < SAT_LO) begin
      dout = OUT_MIN;
    end else begin
      dout = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fir_result_capture.sv
// fir_result_capture
//  Consumes FIR_filter results: skips warm-up samples, quantises each result to 16 bits
//  and stores a programmed number of them in a circular FIFO drained over valid/ready.
//  Ports:
//   clk, reset (async, active-low)
//   in_data/in_valid            incoming FIR samples
//   tap_control/shift/len/start run configuration, latched on start in IDLE
//   busy/done/overflow          run status (done is a 1-cycle pulse, overflow is sticky)
//   count                       FIFO occupancy
//   rd_data/rd_valid/rd_ready   first-word fall-through read port
module fir_result_capture
  import fir_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_valid,
  input  logic        [2:0]       tap_control,
  input  logic        [4:0]       shift,
  input  logic        [AW:0]      len,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic        [AW:0]      count,
  output logic signed [OUT_W-1:0] rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready
);

  state_t state;
  state_t next_state;

  logic [2:0]  tap_l;
  logic [4:0]  shift_l;
  logic [AW:0] len_l;
  logic [AW:0] sample_cnt;
  logic        warm_last;
  logic        cap_last;
  logic        start_run;

  logic signed [OUT_W-1:0] quant;
  logic                    pipe_valid;
  logic signed [OUT_W-1:0] pipe_data;

  logic signed [OUT_W-1:0] mem [DEPTH];
  logic [AW:0]             wr_ptr;
  logic [AW:0]             rd_ptr;
  logic signed [OUT_W-1:0] last_data;
  logic                    full;
  logic                    pop;
  logic                    push_ok;

  assign start_run = (state == IDLE) && start;
  assign warm_last = (sample_cnt == {{(AW-2){1'b0}}, tap_l});
  assign cap_last  = (sample_cnt == (len_l - (AW+1)'(1)));

  fir_round_sat u_round_sat (
    .din   (in_data),
    .shift (shift_l),
    .dout  (quant)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (len == '0) ? DONE : WARMUP;
      WARMUP:  if (in_valid && warm_last) next_state = CAPTURE;
      CAPTURE: if (in_valid && cap_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == WARMUP) || (state == CAPTURE);
    done = (state == DONE);
  end

  // Configuration is frozen for the whole run; the sample counter is reused
  // for warm-up and capture phases
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap_l      <= '0;
      shift_l    <= '0;
      len_l      <= '0;
      sample_cnt <= '0;
    end else if (start_run) begin
      tap_l      <= tap_control;
      shift_l    <= shift;
      len_l      <= len;
      sample_cnt <= '0;
    end else if (state == WARMUP && in_valid) begin
      sample_cnt <= warm_last ? '0 : sample_cnt + (AW+1)'(1);
    end else if (state == CAPTURE && in_valid) begin
      sample_cnt <= sample_cnt + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid <= 1'b0;
      pipe_data  <= '0;
    end else begin
      pipe_valid <= (state == CAPTURE) && in_valid;
      if ((state == CAPTURE) && in_valid) begin
        pipe_data <= quant;
      end
    end
  end

  // A pop in the same cycle frees a slot, so a write at full is still accepted
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_valid = (count != '0);
  assign pop     = rd_valid && rd_ready;
  assign push_ok = pipe_valid && (!full || pop);
  assign rd_data = rd_valid ? mem[rd_ptr[AW-1:0]] : last_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_data <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + (AW+1)'(1);
        last_data <= mem[rd_ptr[AW-1:0]];
      end
      if (pipe_valid && full && !pop) begin
        overflow <= 1'b1;
      end else if (start_run) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= pipe_data;
    end
  end

endmodule

// File: tb/tb_fir_result_capture.sv
// tb_fir_result_capture
//  Directed bench for fir_result_capture with hand-computed expected values.
module tb_fir_result_capture;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic signed [31:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic [2:0]         tap_control = '0;
  logic [4:0]         shift = '0;
  logic [8:0]         len = '0;
  logic               start = 1'b0;
  logic               busy;
  logic               done;
  logic               overflow;
  logic [8:0]         count;
  logic signed [15:0] rd_data;
  logic               rd_valid;
  logic               rd_ready = 1'b0;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int d0;

  fir_result_capture dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .tap_control (tap_control),
    .shift       (shift),
    .len         (len),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .count       (count),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic signed [31:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic startRun(input logic [2:0] t, input logic [4:0] s, input logic [8:0] l);
    tap_control = t;
    shift       = s;
    len         = l;
    start       = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic popExpect(input string tag, input logic signed [31:0] exp);
    checkOutput({tag, "_valid"}, {31'd0, rd_valid}, 32'sd1);
    checkOutput(tag, rd_data, exp);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    #12;
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_done", {31'd0, done}, 0);
    checkOutput("rst_ovf", {31'd0, overflow}, 0);
    checkOutput("rst_count", {23'd0, count}, 0);
    checkOutput("rst_rdvalid", {31'd0, rd_valid}, 0);
    checkOutput("rst_rddata", rd_data, 0);
    reset = 1'b1;
    tick();

    // 1: seven warm-up samples dropped, four captured, twelfth ignored
    d0 = done_cnt;
    startRun(3'd6, 5'd0, 9'd4);
    checkOutput("t1_busy", {31'd0, busy}, 1);
    for (int i = 1; i <= 12; i++) applyStimulus(i);
    checkOutput("t1_count", {23'd0, count}, 4);
    checkOutput("t1_done_cnt", done_cnt - d0, 1);
    checkOutput("t1_busy_end", {31'd0, busy}, 0);
    for (int i = 8; i <= 11; i++) popExpect("t1_data", i);
    checkOutput("t1_empty", {31'd0, rd_valid}, 0);

    // 2: rounding and saturation with shift=4
    startRun(3'd0, 5'd4, 9'd4);
    applyStimulus(0);
    applyStimulus(24);
    checkOutput("t2_lat_count", {23'd0, count}, 0);
    checkOutput("t2_lat_valid", {31'd0, rd_valid}, 0);
    applyStimulus(-24);
    checkOutput("t2_first_count", {23'd0, count}, 1);
    checkOutput("t2_first_data", rd_data, 2);
    applyStimulus(32'sh7FFF_FFFF);
    applyStimulus(32'sh8000_0000);
    tick();
    popExpect("t2_pos", 2);
    popExpect("t2_neg", -1);
    popExpect("t2_max", 32767);
    popExpect("t2_min", -32768);
    checkOutput("t2_empty", {31'd0, rd_valid}, 0);
    checkOutput("t2_hold", rd_data, -32768);

    // 3: len=DEPTH+2 with no reader fills the FIFO and overflows
    d0 = done_cnt;
    startRun(3'd0, 5'd0, 9'd258);
    applyStimulus(0);
    for (int i = 0; i < 257; i++) applyStimulus(i);
    checkOutput("t3_busy_257", {31'd0, busy}, 1);
    applyStimulus(257);
    tick();
    checkOutput("t3_done_cnt", done_cnt - d0, 1);
    checkOutput("t3_count", {23'd0, count}, 256);
    checkOutput("t3_ovf", {31'd0, overflow}, 1);

    // 4: push and pop in the same cycle while full
    d0 = done_cnt;
    startRun(3'd0, 5'd0, 9'd1);
    checkOutput("t4_ovf_clr", {31'd0, overflow}, 0);
    applyStimulus(0);
    applyStimulus(999);
    checkOutput("t4_head", rd_data, 0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    checkOutput("t4_count", {23'd0, count}, 256);
    checkOutput("t4_ovf", {31'd0, overflow}, 0);
    checkOutput("t4_done_cnt", done_cnt - d0, 1);
    for (int i = 1; i < 256; i++) popExpect("t4_drain", i);
    popExpect("t4_last", 999);
    checkOutput("t4_empty", {31'd0, rd_valid}, 0);

    // 5: zero-length run goes straight to done
    startRun(3'd2, 5'd0, 9'd0);
    checkOutput("t5_done", {31'd0, done}, 1);
    checkOutput("t5_busy", {31'd0, busy}, 0);
    tick();
    checkOutput("t5_done_end", {31'd0, done}, 0);
    checkOutput("t5_busy_end", {31'd0, busy}, 0);

    // 6: asynchronous reset in the middle of a capture run
    startRun(3'd0, 5'd0, 9'd20);
    applyStimulus(0);
    for (int i = 0; i < 10; i++) applyStimulus(100 + i);
    tick();
    checkOutput("t6_count_pre", {23'd0, count}, 10);
    d0 = done_cnt;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6_count", {23'd0, count}, 0);
    checkOutput("t6_rdvalid", {31'd0, rd_valid}, 0);
    checkOutput("t6_busy", {31'd0, busy}, 0);
    checkOutput("t6_rddata", rd_data, 0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    checkOutput("t6_no_done", done_cnt - d0, 0);
    startRun(3'd1, 5'd0, 9'd2);
    applyStimulus(0);
    applyStimulus(0);
    applyStimulus(50);
    applyStimulus(60);
    tick();
    checkOutput("t6_re_count", {23'd0, count}, 2);
    checkOutput("t6_re_done", done_cnt - d0, 1);
    popExpect("t6_re_a", 50);
    popExpect("t6_re_b", 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
